hdmi_period_scheduler: RTL and testbench
========================================

// Module: hdmi_period_scheduler
// PURPOSE
//  Per-pixel HDMI period sequencer. Sits between the cx/cy raster counter and the three tmds_encoder lanes.
//  Each pixel is classified as control, video preamble, video guard band, video, data-island preamble,
//  island guard band or island data. Drives the encoder mode and the CTL preamble bits.
//  Pulls 32-pixel data-island packets from a packet source, as many per line as fit in horizontal blanking.
// PARAMETERS
//  BIT_WIDTH     10  width of cx, frame_width, screen_start_x
//  BIT_HEIGHT    10  width of cy, screen_start_y
//  ISLAND_START  20  first pixel (cx) of an island preamble; must be >=1
//  MAX_PACKETS   18  max packets per island (one island per line)
// PORTS
//  pxl_clk         in   1          pixel clock; only clock
//  rst             in   1          synchronous, active-high reset
//  cx              in   BIT_WIDTH  current pixel x (0..frame_width-1, wraps)
//  cy              in   BIT_HEIGHT current line y
//  frame_width     in   BIT_WIDTH  total pixels per line (static)
//  screen_start_x  in   BIT_WIDTH  first active-video x (static)
//  screen_start_y  in   BIT_HEIGHT first active-video line (static)
//  pkt_valid       in   1          source has a full packet ready
//  pkt_ready       out  1          packet slot offered; transfer when pkt_valid&&pkt_ready
//  pkt_word        out  5          word index 0..31 of packet being sent (0 outside island data)
//  mode            out  3          0 ctrl,1 video,2 video GB,3 island data,4 island GB
//  ctl             out  4          {CTL3..CTL0} for lanes 1,2; 0 except in preambles
//  island_active   out  1          high from island preamble through trailing guard band
// BEHAVIOUR
//  - All outputs registered. The output cycle after cx=p describes pixel p.
//  - Reset: mode=0, ctl=0, pkt_ready=0, pkt_word=0, island_active=0, FSM=CTRL, packet count=0.
//    Reset mid-island/mid-video aborts immediately. Ctrl resumes next cycle; no packet is consumed.
//  - Let V = screen_start_x-10 (video preamble start) and LIM = screen_start_x-56
//    (last packet start that leaves 32 data + 2 GB + 12 min control before V).
//  - FSM: CTRL, ISL_PRE, ISL_GBL, ISL_DATA, ISL_GBT, VID_PRE, VID_GB, VIDEO.
//  - Active line = cy>=screen_start_y.
//    On active lines, pixels V..V+7 are VID_PRE (mode 0, ctl=4'b0001) and
//    V+8..V+9 are VID_GB (mode 2). Pixels screen_start_x..frame_width-1 are VIDEO (mode 1).
//    Inactive lines stay CTRL there.
//  - Island start: at pixel ISLAND_START-1 (state CTRL), pkt_ready=1 iff ISLAND_START+10<=LIM.
//    If pkt_valid, pixels ISLAND_START..+7 are ISL_PRE (mode 0, ctl=4'b0101) and +8..+9 are ISL_GBL (mode 4).
//    Then ISL_DATA (mode 3, pkt_word 0..31). No valid means the line stays CTRL.
//    Island start applies on every line, active or not.
//  - At pkt_word=31, pkt_ready=1 iff next pixel<=LIM and count<MAX_PACKETS.
//    Handshake -> next pixel starts a new packet at word 0, count+1.
//    Otherwise 2 pixels of ISL_GBT (mode 4), then CTRL.
//  - pkt_ready is never high outside those two decision points.
//    pkt_valid outside them is ignored. pkt_valid falling mid-packet does not abort the packet.
//  - Count clears at cx wrap (frame_width-1 -> 0). The video period ends exactly at the wrap.
//  - Video and island windows never overlap by construction of LIM.
//  - If ISLAND_START+10>LIM, no island is ever scheduled.
//  - island_active=1 in ISL_PRE/GBL/DATA/GBT, else 0.
// TESTING
//  - 640x480 (fw=800, ssx=160, ssy=45), no valid, cy=100 -> ctl=1 at px150-157, mode2 at 158-159,
//    mode1 at 160-799; pkt_ready only at px19.
//  - Same, pkt_valid held 1 -> ctl=5 at 20-27, mode4 at 28-29, packets at 30/62/94.
//    pkt_ready at px61 and px93 (=1) and px125 (=0, 126>104). GBT at 126-127.
//  - pkt_valid drops after first handshake -> one packet 30-61, pkt_ready=1 at px61 unaccepted, GBT at 62-63.
//  - MAX_PACKETS=1, valid held -> exactly one packet per line; pkt_ready=0 at px61.
//  - cy=10 (vertical blanking), valid held -> island as above, no VID_PRE/VIDEO; mode=0 at px150-799.
//  - rst asserted at px40 (mid-packet) -> next cycle mode=0, island_active=0.
//    Island restarts normally on next line; count=0.

Source files
------------

// File: rtl/hdmi_period_scheduler.sv
// Per-pixel HDMI period sequencer: classifies each raster pixel into control, video or
// data-island periods and pulls 32-pixel island packets from a packet source.
module hdmi_period_scheduler #(
   parameter int unsigned BIT_WIDTH    = 10,
   parameter int unsigned BIT_HEIGHT   = 10,
   parameter int unsigned ISLAND_START = 20,
   parameter int unsigned MAX_PACKETS  = 18
) (
   input  logic                  pxl_clk,
   input  logic                  rst,
   input  logic [BIT_WIDTH-1:0]  cx,
   input  logic [BIT_HEIGHT-1:0] cy,
   input  logic [BIT_WIDTH-1:0]  frame_width,
   input  logic [BIT_WIDTH-1:0]  screen_start_x,
   input  logic [BIT_HEIGHT-1:0] screen_start_y,
   input  logic                  pkt_valid,
   output logic                  pkt_ready,
   output logic [4:0]            pkt_word,
   output logic [2:0]            mode,
   output logic [3:0]            ctl,
   output logic                  island_active
);

   // Widened x arithmetic so screen_start_x-56 style bounds never underflow.
   localparam int unsigned XW = BIT_WIDTH + 8;
   localparam int unsigned CW = $clog2(MAX_PACKETS + 1);

   localparam logic [2:0] StCtrl    = 3'd0;
   localparam logic [2:0] StIslPre  = 3'd1;
   localparam logic [2:0] StIslGbl  = 3'd2;
   localparam logic [2:0] StIslData = 3'd3;
   localparam logic [2:0] StIslGbt  = 3'd4;
   localparam logic [2:0] StVidPre  = 3'd5;
   localparam logic [2:0] StVidGb   = 3'd6;
   localparam logic [2:0] StVideo   = 3'd7;

   logic [2:0]    state_q, state_d, base_state;
   logic [4:0]    word_q, word_d;
   logic          gbt_q, gbt_d;
   logic [CW-1:0] count_q, count_d;
   logic [2:0]    mode_q, mode_d;
   logic [3:0]    ctl_q, ctl_d;
   logic          ready_q, ready_d;
   logic          isl_q, isl_d;
   logic [XW-1:0] cx_w, ssx_w;
   logic          active, handshake;

   // frame_width only bounds cx; video simply runs until the wrap.
   logic unused_fw;
   assign unused_fw = ^frame_width;

   always_comb begin
      cx_w      = XW'(cx);
      ssx_w     = XW'(screen_start_x);
      active    = (cy >= screen_start_y);
      handshake = ready_q && pkt_valid;

      // Classification for pixels outside an island.
      if (active && (cx_w + XW'(10) >= ssx_w) && (cx_w + XW'(2) < ssx_w)) begin
         base_state = StVidPre;
      end else if (active && (cx_w + XW'(2) >= ssx_w) && (cx_w < ssx_w)) begin
         base_state = StVidGb;
      end else if (active && (cx_w >= ssx_w)) begin
         base_state = StVideo;
      end else if ((cx_w == XW'(ISLAND_START)) && handshake) begin
         base_state = StIslPre;
      end else begin
         base_state = StCtrl;
      end

      state_d = base_state;
      word_d  = 5'd0;
      gbt_d   = 1'b0;
      count_d = (cx == '0) ? '0 : count_q;
      if (handshake) count_d = count_d + CW'(1);

      case (state_q)
         StIslPre: state_d = (cx_w >= XW'(ISLAND_START + 8)) ? StIslGbl : StIslPre;
         StIslGbl: state_d = (cx_w >= XW'(ISLAND_START + 10)) ? StIslData : StIslGbl;
         StIslData: begin
            if (word_q != 5'd31) begin
               state_d = StIslData;
               word_d  = word_q + 5'd1;
            end else if (handshake) begin
               state_d = StIslData;
            end else begin
               state_d = StIslGbt;
            end
         end
         StIslGbt: begin
            if (!gbt_q) begin
               state_d = StIslGbt;
               gbt_d   = 1'b1;
            end
         end
         default: ;
      endcase

      mode_d = 3'd0;
      ctl_d  = 4'b0000;
      case (state_d)
         StIslPre:  ctl_d  = 4'b0101;
         StIslGbl:  mode_d = 3'd4;
         StIslData: mode_d = 3'd3;
         StIslGbt:  mode_d = 3'd4;
         StVidPre:  ctl_d  = 4'b0001;
         StVidGb:   mode_d = 3'd2;
         StVideo:   mode_d = 3'd1;
         default: ;
      endcase

      isl_d   = (state_d == StIslPre) || (state_d == StIslGbl) ||
                (state_d == StIslData) || (state_d == StIslGbt);
      ready_d = ((state_d == StCtrl) && (cx_w == XW'(ISLAND_START - 1)) &&
                 (XW'(ISLAND_START + 66) <= ssx_w)) ||
                ((state_d == StIslData) && (word_d == 5'd31) &&
                 (cx_w + XW'(57) <= ssx_w) && (count_d < CW'(MAX_PACKETS)));
   end

   always_ff @(posedge pxl_clk) begin
      if (rst) begin
         state_q <= StCtrl;
         word_q  <= 5'd0;
         gbt_q   <= 1'b0;
         count_q <= '0;
         mode_q  <= 3'd0;
         ctl_q   <= 4'b0000;
         ready_q <= 1'b0;
         isl_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         gbt_q   <= gbt_d;
         count_q <= count_d;
         mode_q  <= mode_d;
         ctl_q   <= ctl_d;
         ready_q <= ready_d;
         isl_q   <= isl_d;
      end
   end

   assign pkt_ready     = ready_q;
   assign pkt_word      = word_q;
   assign mode          = mode_q;
   assign ctl           = ctl_q;
   assign island_active = isl_q;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Scoreboard bench for hdmi_period_scheduler on a 640x480 raster (fw=800, ssx=160, ssy=45).
module tb_hdmi_period_scheduler;

   logic       pxl_clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] cx = '0;
   logic [9:0] cy = '0;
   logic [9:0] frame_width = 10'd800;
   logic [9:0] screen_start_x = 10'd160;
   logic [9:0] screen_start_y = 10'd45;
   logic       pkt_valid = 1'b0;

   logic       ready_a, ready_b, isl_a, isl_b;
   logic [4:0] word_a, word_b;
   logic [2:0] mode_a, mode_b;
   logic [3:0] ctl_a, ctl_b;

   int checks = 0;
   int failures = 0;
   logic [13:0] exp_q[$];

   always #5 pxl_clk = ~pxl_clk;

   hdmi_period_scheduler dut (
      .pxl_clk(pxl_clk), .rst(rst), .cx(cx), .cy(cy), .frame_width(frame_width),
      .screen_start_x(screen_start_x), .screen_start_y(screen_start_y),
      .pkt_valid(pkt_valid), .pkt_ready(ready_a), .pkt_word(word_a), .mode(mode_a),
      .ctl(ctl_a), .island_active(isl_a)
   );

   hdmi_period_scheduler #(.MAX_PACKETS(1)) dut_m1 (
      .pxl_clk(pxl_clk), .rst(rst), .cx(cx), .cy(cy), .frame_width(frame_width),
      .screen_start_x(screen_start_x), .screen_start_y(screen_start_y),
      .pkt_valid(pkt_valid), .pkt_ready(ready_b), .pkt_word(word_b), .mode(mode_b),
      .ctl(ctl_b), .island_active(isl_b)
   );

   // Expected {mode, ctl, pkt_ready, pkt_word, island_active} for pixel p.
   function automatic logic [13:0] exp_pixel(int p, bit act, int npk, int maxp, int rst_at);
      logic [2:0] m;
      logic [3:0] c;
      logic       r;
      logic [4:0] w;
      logic       i;
      m = 3'd0; c = 4'd0; r = 1'b0; w = 5'd0; i = 1'b0;
      if (rst_at >= 0 && p == rst_at) return 14'd0;
      if (act && p >= 150 && p <= 157) c = 4'd1;
      if (act && (p == 158 || p == 159)) m = 3'd2;
      if (act && p >= 160) m = 3'd1;
      if (!(rst_at >= 0 && p > rst_at)) begin
         if (p == 19) r = 1'b1;
         if (npk > 0) begin
            if (p >= 20 && p <= 27) begin c = 4'd5; i = 1'b1; end
            if (p == 28 || p == 29) begin m = 3'd4; i = 1'b1; end
            if (p >= 30 && p < 30 + 32 * npk) begin
               m = 3'd3;
               w = 5'((p - 30) % 32);
               i = 1'b1;
               if (w == 5'd31) r = (p + 1 + 56 <= 160) && ((p - 30) / 32 + 1 < maxp);
            end
            if (p == 30 + 32 * npk || p == 31 + 32 * npk) begin m = 3'd4; i = 1'b1; end
         end
      end
      return {m, c, r, w, i};
   endfunction

   // vmode: 0 no valid, 1 valid held, 2 valid only through the first handshake.
   task automatic run_line(input string name, input int y, input int vmode, input int npk,
                           input int maxp, input bit use_m1, input int rst_at);
      logic [13:0] got, expv;
      for (int p = 0; p < 800; p++) begin
         cx = 10'(p);
         cy = 10'(y);
         pkt_valid = (vmode == 1) || (vmode == 2 && p <= 20);
         rst = (p == rst_at);
         exp_q.push_back(exp_pixel(p, (y >= 45), npk, maxp, rst_at));
         @(posedge pxl_clk);
         @(negedge pxl_clk);
         got = use_m1 ? {mode_b, ctl_b, ready_b, word_b, isl_b}
                      : {mode_a, ctl_a, ready_a, word_a, isl_a};
         expv = exp_q.pop_front();
         checks++;
         if (got !== expv) begin
            failures++;
            $display("FAIL %s px%0d: got mode=%0d ctl=%0d rdy=%0d word=%0d isl=%0d, want mode=%0d ctl=%0d rdy=%0d word=%0d isl=%0d",
                     name, p, got[13:11], got[10:7], got[6], got[5:1], got[0],
                     expv[13:11], expv[10:7], expv[6], expv[5:1], expv[0]);
         end
      end
      rst = 1'b0;
      pkt_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cx = '0;
      repeat (2) @(posedge pxl_clk);
      @(negedge pxl_clk);
      checks++;
      if ({mode_a, ctl_a, ready_a, word_a, isl_a} !== 14'd0) begin
         failures++;
         $display("FAIL reset_default: got %h want 0", {mode_a, ctl_a, ready_a, word_a, isl_a});
      end
      checks++;
      if ({mode_b, ctl_b, ready_b, word_b, isl_b} !== 14'd0) begin
         failures++;
         $display("FAIL reset_max1: got %h want 0", {mode_b, ctl_b, ready_b, word_b, isl_b});
      end
      rst = 1'b0;
   endtask

   task automatic test_no_valid();
      run_line("no_valid", 100, 0, 0, 18, 1'b0, -1);
   endtask

   task automatic test_back_to_back();
      run_line("back_to_back", 100, 1, 3, 18, 1'b0, -1);
   endtask

   task automatic test_valid_drop();
      run_line("valid_drop", 100, 2, 1, 18, 1'b0, -1);
   endtask

   task automatic test_max_packets();
      run_line("max_packets1", 100, 1, 1, 1, 1'b1, -1);
   endtask

   task automatic test_vblank();
      run_line("vblank", 10, 1, 3, 18, 1'b0, -1);
   endtask

   task automatic test_reset_mid_packet();
      run_line("reset_mid", 100, 1, 3, 18, 1'b0, 40);
      run_line("after_reset", 101, 1, 3, 18, 1'b0, -1);
   endtask

   initial begin
      test_reset();
      test_no_valid();
      test_back_to_back();
      test_valid_drop();
      test_max_packets();
      test_vblank();
      test_reset_mid_packet();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
